// File: rtl/svci_cmd_queue.sv
// In-order SVCI command queue with an outstanding-response limiter toward the AXI bridge.
// The response path is a combinational passthrough that retires the outstanding count.
module svci_cmd_queue #(
  parameter int unsigned TAG       = 1,
  parameter int unsigned ID        = 1,
  parameter int unsigned PRTY      = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            rst_l,
  // upstream commands
  input  logic            in_cmd_valid,
  output logic            in_cmd_ready,
  input  logic [TAG-1:0]  in_cmd_tag,
  input  logic [ID-1:0]   in_cmd_mid,
  input  logic [63:0]     in_cmd_addr,
  input  logic [63:0]     in_cmd_wdata,
  input  logic [7:0]      in_cmd_wbe,
  input  logic [2:0]      in_cmd_length,
  input  logic [2:0]      in_cmd_opc,
  input  logic [PRTY-1:0] in_cmd_prty,
  // commands toward the bridge
  output logic            out_cmd_valid,
  input  logic            out_cmd_ready,
  output logic [TAG-1:0]  out_cmd_tag,
  output logic [ID-1:0]   out_cmd_mid,
  output logic [63:0]     out_cmd_addr,
  output logic [63:0]     out_cmd_wdata,
  output logic [7:0]      out_cmd_wbe,
  output logic [2:0]      out_cmd_length,
  output logic [2:0]      out_cmd_opc,
  output logic [PRTY-1:0] out_cmd_prty,
  // responses from the bridge
  input  logic            out_rsp_valid,
  output logic            out_rsp_ready,
  input  logic [TAG-1:0]  out_rsp_tag,
  input  logic [ID-1:0]   out_rsp_mid,
  input  logic [63:0]     out_rsp_rdata,
  input  logic [3:0]      out_rsp_opc,
  input  logic [PRTY-1:0] out_rsp_prty,
  // responses to the requester
  output logic            in_rsp_valid,
  input  logic            in_rsp_ready,
  output logic [TAG-1:0]  in_rsp_tag,
  output logic [ID-1:0]   in_rsp_mid,
  output logic [63:0]     in_rsp_rdata,
  output logic [3:0]      in_rsp_opc,
  output logic [PRTY-1:0] in_rsp_prty,
  // status
  output logic [3:0]      outst_cnt,
  output logic            idle,
  output logic            outst_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [TAG-1:0]  tag;
    logic [ID-1:0]   mid;
    logic [63:0]     addr;
    logic [63:0]     wdata;
    logic [7:0]      wbe;
    logic [2:0]      length;
    logic [2:0]      opc;
    logic [PRTY-1:0] prty;
  } cmd_entry_t;

  cmd_entry_t      mem [DEPTH];
  cmd_entry_t      head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            head_exp;
  logic            push;
  logic            pop;
  logic            retire;
  logic            inc;

  assign head     = mem[rd_ptr];
  assign head_exp = (head.opc == 3'b000) || (head.opc == 3'b011);

  // Gate only response-expecting heads; a gated head stalls everything behind it.
  assign in_cmd_ready  = (count != CW'(DEPTH));
  assign out_cmd_valid = (count != CW'(0)) && (!head_exp || (outst_cnt < 4'(MAX_OUTST)));

  assign push   = in_cmd_valid && in_cmd_ready;
  assign pop    = out_cmd_valid && out_cmd_ready;
  assign inc    = pop && head_exp;
  assign retire = out_rsp_valid && in_rsp_ready && (out_rsp_opc[3:2] != 2'b10);

  assign out_cmd_tag    = head.tag;
  assign out_cmd_mid    = head.mid;
  assign out_cmd_addr   = head.addr;
  assign out_cmd_wdata  = head.wdata;
  assign out_cmd_wbe    = head.wbe;
  assign out_cmd_length = head.length;
  assign out_cmd_opc    = head.opc;
  assign out_cmd_prty   = head.prty;

  assign in_rsp_valid  = out_rsp_valid;
  assign out_rsp_ready = in_rsp_ready;
  assign in_rsp_tag    = out_rsp_tag;
  assign in_rsp_mid    = out_rsp_mid;
  assign in_rsp_rdata  = out_rsp_rdata;
  assign in_rsp_opc    = out_rsp_opc;
  assign in_rsp_prty   = out_rsp_prty;

  assign idle = (count == CW'(0)) && (outst_cnt == 4'd0);

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{tag: in_cmd_tag, mid: in_cmd_mid, addr: in_cmd_addr,
                       wdata: in_cmd_wdata, wbe: in_cmd_wbe, length: in_cmd_length,
                       opc: in_cmd_opc, prty: in_cmd_prty};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A retire with nothing outstanding is flagged rather than allowed to underflow.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      outst_cnt <= 4'd0;
      outst_err <= 1'b0;
    end else begin
      case ({inc, retire})
        2'b10: outst_cnt <= outst_cnt + 4'd1;
        2'b01: begin
          if (outst_cnt == 4'd0) outst_err <= 1'b1;
          else                   outst_cnt <= outst_cnt - 4'd1;
        end
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_svci_cmd_queue.sv
// Directed bench for svci_cmd_queue: ordering, backpressure, outstanding gate,
// response passthrough/retire rules, error flag and asynchronous reset.
module tb_svci_cmd_queue;

  localparam int unsigned TAG = 4;
  localparam int unsigned ID  = 2;

  logic            clk = 1'b0;
  logic            rst_l;
  logic            in_cmd_valid, in_cmd_ready;
  logic [TAG-1:0]  in_cmd_tag;
  logic [ID-1:0]   in_cmd_mid;
  logic [63:0]     in_cmd_addr, in_cmd_wdata;
  logic [7:0]      in_cmd_wbe;
  logic [2:0]      in_cmd_length, in_cmd_opc;
  logic [0:0]      in_cmd_prty;
  logic            out_cmd_valid, out_cmd_ready;
  logic [TAG-1:0]  out_cmd_tag;
  logic [ID-1:0]   out_cmd_mid;
  logic [63:0]     out_cmd_addr, out_cmd_wdata;
  logic [7:0]      out_cmd_wbe;
  logic [2:0]      out_cmd_length, out_cmd_opc;
  logic [0:0]      out_cmd_prty;
  logic            out_rsp_valid, out_rsp_ready;
  logic [TAG-1:0]  out_rsp_tag;
  logic [ID-1:0]   out_rsp_mid;
  logic [63:0]     out_rsp_rdata;
  logic [3:0]      out_rsp_opc;
  logic [0:0]      out_rsp_prty;
  logic            in_rsp_valid, in_rsp_ready;
  logic [TAG-1:0]  in_rsp_tag;
  logic [ID-1:0]   in_rsp_mid;
  logic [63:0]     in_rsp_rdata;
  logic [3:0]      in_rsp_opc;
  logic [0:0]      in_rsp_prty;
  logic [3:0]      outst_cnt;
  logic            idle, outst_err;

  int errors = 0;
  int checks = 0;

  svci_cmd_queue #(.TAG(TAG), .ID(ID), .PRTY(1), .DEPTH(4), .MAX_OUTST(2)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_cmd_valid(in_cmd_valid), .in_cmd_ready(in_cmd_ready),
    .in_cmd_tag(in_cmd_tag), .in_cmd_mid(in_cmd_mid), .in_cmd_addr(in_cmd_addr),
    .in_cmd_wdata(in_cmd_wdata), .in_cmd_wbe(in_cmd_wbe), .in_cmd_length(in_cmd_length),
    .in_cmd_opc(in_cmd_opc), .in_cmd_prty(in_cmd_prty),
    .out_cmd_valid(out_cmd_valid), .out_cmd_ready(out_cmd_ready),
    .out_cmd_tag(out_cmd_tag), .out_cmd_mid(out_cmd_mid), .out_cmd_addr(out_cmd_addr),
    .out_cmd_wdata(out_cmd_wdata), .out_cmd_wbe(out_cmd_wbe), .out_cmd_length(out_cmd_length),
    .out_cmd_opc(out_cmd_opc), .out_cmd_prty(out_cmd_prty),
    .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready),
    .out_rsp_tag(out_rsp_tag), .out_rsp_mid(out_rsp_mid), .out_rsp_rdata(out_rsp_rdata),
    .out_rsp_opc(out_rsp_opc), .out_rsp_prty(out_rsp_prty),
    .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .in_rsp_tag(in_rsp_tag), .in_rsp_mid(in_rsp_mid), .in_rsp_rdata(in_rsp_rdata),
    .in_rsp_opc(in_rsp_opc), .in_rsp_prty(in_rsp_prty),
    .outst_cnt(outst_cnt), .idle(idle), .outst_err(outst_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] t, input logic [2:0] o, input logic [63:0] a);
    in_cmd_valid  = 1'b1;
    in_cmd_tag    = t;
    in_cmd_opc    = o;
    in_cmd_addr   = a;
    in_cmd_wdata  = a ^ 64'h5555_5555_5555_5555;
    in_cmd_mid    = 2'd1;
    in_cmd_wbe    = 8'hFF;
    in_cmd_length = 3'd3;
    in_cmd_prty   = 1'b0;
    step();
    in_cmd_valid  = 1'b0;
  endtask

  task automatic respond(input logic [3:0] o);
    out_rsp_valid = 1'b1;
    out_rsp_opc   = o;
    step();
    out_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0;
    in_cmd_valid = 1'b0; in_cmd_tag = '0; in_cmd_mid = '0; in_cmd_addr = '0;
    in_cmd_wdata = '0; in_cmd_wbe = '0; in_cmd_length = '0; in_cmd_opc = '0; in_cmd_prty = '0;
    out_cmd_ready = 1'b0;
    out_rsp_valid = 1'b0; out_rsp_tag = '0; out_rsp_mid = '0; out_rsp_rdata = '0;
    out_rsp_opc = '0; out_rsp_prty = '0;
    in_rsp_ready = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 64'(in_cmd_ready), 64'd1);
    check("rst_out_valid", 64'(out_cmd_valid), 64'd0);
    check("rst_outst", 64'(outst_cnt), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_err", 64'(outst_err), 64'd0);
    rst_l = 1'b1;
    step();

    // single read round trip
    out_cmd_ready = 1'b1;
    push_cmd(4'd1, 3'b000, 64'h1000);
    check("t1_valid", 64'(out_cmd_valid), 64'd1);
    check("t1_addr", out_cmd_addr, 64'h1000);
    check("t1_tag", 64'(out_cmd_tag), 64'd1);
    step();
    check("t1_outst", 64'(outst_cnt), 64'd1);
    check("t1_idle0", 64'(idle), 64'd0);
    check("t1_drained", 64'(out_cmd_valid), 64'd0);
    respond(4'b0000);
    check("t1_outst0", 64'(outst_cnt), 64'd0);
    check("t1_idle1", 64'(idle), 64'd1);

    // fill to DEPTH, hold off a fifth, then drain in order
    out_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(4'(i), 3'b010, 64'(32'h2000 + i));
    check("t2_full", 64'(in_cmd_ready), 64'd0);
    in_cmd_valid = 1'b1; in_cmd_tag = 4'd4; in_cmd_opc = 3'b010;
    step();
    check("t2_held", 64'(in_cmd_ready), 64'd0);
    check("t2_head", 64'(out_cmd_tag), 64'd0);
    out_cmd_ready = 1'b1;
    step();
    out_cmd_ready = 1'b0;
    check("t2_reopen", 64'(in_cmd_ready), 64'd1);
    step();
    in_cmd_valid = 1'b0;
    check("t2_refull", 64'(in_cmd_ready), 64'd0);
    out_cmd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("t2_v%0d", i), 64'(out_cmd_valid), 64'd1);
      check($sformatf("t2_tag%0d", i), 64'(out_cmd_tag), 64'(i));
      step();
    end
    check("t2_empty", 64'(out_cmd_valid), 64'd0);

    // outstanding gate at MAX_OUTST=2
    out_cmd_ready = 1'b0;
    push_cmd(4'hA, 3'b000, 64'hA0);
    push_cmd(4'hB, 3'b000, 64'hB0);
    push_cmd(4'hC, 3'b000, 64'hC0);
    push_cmd(4'hD, 3'b010, 64'hD0);
    out_cmd_ready = 1'b1;
    step();
    step();
    check("t3_outst2", 64'(outst_cnt), 64'd2);
    check("t3_gated", 64'(out_cmd_valid), 64'd0);
    check("t3_head_c", 64'(out_cmd_tag), 64'hC);
    step();
    check("t3_still", 64'(out_cmd_valid), 64'd0);
    respond(4'b0000);
    check("t3_c_valid", 64'(out_cmd_valid), 64'd1);
    check("t3_c_tag", 64'(out_cmd_tag), 64'hC);
    step();
    check("t3_d_valid", 64'(out_cmd_valid), 64'd1);
    check("t3_d_tag", 64'(out_cmd_tag), 64'hD);
    step();
    check("t3_done", 64'(out_cmd_valid), 64'd0);
    check("t3_outst", 64'(outst_cnt), 64'd2);
    respond(4'b0000);
    respond(4'b0011);
    check("t3_outst0", 64'(outst_cnt), 64'd0);

    // posted-write error response: forwarded, not retired
    out_rsp_valid = 1'b1; out_rsp_opc = 4'b1001; out_rsp_tag = 4'd5;
    out_rsp_mid = 2'd3; out_rsp_rdata = 64'hDEAD_BEEF_0123_4567; out_rsp_prty = 1'b1;
    in_rsp_ready = 1'b0;
    #1;
    check("t4_ready_pass", 64'(out_rsp_ready), 64'd0);
    in_rsp_ready = 1'b1;
    #1;
    check("t4_valid", 64'(in_rsp_valid), 64'd1);
    check("t4_ready", 64'(out_rsp_ready), 64'd1);
    check("t4_tag", 64'(in_rsp_tag), 64'd5);
    check("t4_mid", 64'(in_rsp_mid), 64'd3);
    check("t4_rdata", in_rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    check("t4_opc", 64'(in_rsp_opc), 64'b1001);
    check("t4_prty", 64'(in_rsp_prty), 64'd1);
    step();
    out_rsp_valid = 1'b0;
    check("t4_outst", 64'(outst_cnt), 64'd0);
    check("t4_noerr", 64'(outst_err), 64'd0);

    // pop and retire in the same cycle
    out_cmd_ready = 1'b1;
    push_cmd(4'd1, 3'b000, 64'h3000);
    step();
    check("t5_outst1", 64'(outst_cnt), 64'd1);
    out_cmd_ready = 1'b0;
    push_cmd(4'd2, 3'b011, 64'h3100);
    out_cmd_ready = 1'b1;
    respond(4'b0000);
    check("t5_same", 64'(outst_cnt), 64'd1);
    check("t5_popped", 64'(out_cmd_valid), 64'd0);
    respond(4'b0000);
    check("t5_outst0", 64'(outst_cnt), 64'd0);

    // spurious response, then async reset with queued entries
    respond(4'b0000);
    check("t6_err", 64'(outst_err), 64'd1);
    check("t6_outst", 64'(outst_cnt), 64'd0);
    out_cmd_ready = 1'b0;
    push_cmd(4'd7, 3'b010, 64'h4000);
    push_cmd(4'd8, 3'b010, 64'h4100);
    push_cmd(4'd9, 3'b010, 64'h4200);
    check("t6_busy", 64'(idle), 64'd0);
    check("t6_valid", 64'(out_cmd_valid), 64'd1);
    #2;
    rst_l = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_cmd_valid), 64'd0);
    check("t6_rst_idle", 64'(idle), 64'd1);
    check("t6_rst_ready", 64'(in_cmd_ready), 64'd1);
    check("t6_rst_err", 64'(outst_err), 64'd0);
    step();
    rst_l = 1'b1;
    step();
    push_cmd(4'd6, 3'b010, 64'h5000);
    check("t6_after_tag", 64'(out_cmd_tag), 64'd6);
    check("t6_after_addr", out_cmd_addr, 64'h5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/svci_cmd_queue.md
# svci_cmd_queue

Command queue and outstanding-transaction limiter that sits directly upstream of the SVCI-to-AXI4 bridge. It accepts SVCI commands from a requester (LSU/DMA), buffers up to DEPTH of them in order, and releases them to the bridge. Reads and non-posted writes are released only while fewer than MAX_OUTST responses are pending. Responses from the bridge pass straight through to the requester and retire the outstanding count.

## Interface
- TAG, 1, SVCI tag width
- ID, 1, SVCI master-id width
- PRTY, 1, parity width
- DEPTH, 4, queue entries; power of two, at least 2
- MAX_OUTST, 4, maximum number of response-expecting commands in flight; range 1..15

- clk  in  1  core clock
- rst_l  in  1  reset; asynchronous, active-low
- in_cmd_valid / in_cmd_ready  in/out  1/1  upstream command handshake
- in_cmd_tag, in_cmd_mid, in_cmd_addr, in_cmd_wdata, in_cmd_wbe, in_cmd_length, in_cmd_opc, in_cmd_prty  in  TAG/ID/64/64/8/3/3/PRTY  upstream command payload
- out_cmd_valid / out_cmd_ready  out/in  1/1  command handshake toward the bridge
- out_cmd_tag … out_cmd_prty  out  same widths as in_cmd_*  queue-head payload
- out_rsp_valid / out_rsp_ready  in/out  1/1  response handshake from the bridge
- out_rsp_tag, out_rsp_mid, out_rsp_rdata, out_rsp_opc, out_rsp_prty  in  TAG/ID/64/4/PRTY  response payload from the bridge
- in_rsp_valid / in_rsp_ready  out/in  1/1  response handshake to the requester
- in_rsp_tag, in_rsp_mid, in_rsp_rdata, in_rsp_opc, in_rsp_prty  out  TAG/ID/64/4/PRTY  response payload to the requester
- outst_cnt  out  4  current number of in-flight response-expecting commands
- idle  out  1  asserted when the queue is empty and outst_cnt is 0
- outst_err  out  1  sticky flag: a response arrived while outst_cnt was 0

## Operation
- Opcode classes:
  - opc 000: read.
  - opc 010: posted write.
  - opc 011: non-posted write.
  - A command expects a response (exp_rsp) when opc is 000 or 011. All other opcodes are queued and forwarded with exp_rsp=0.
- Storage:
  - DEPTH-entry circular buffer holding the full payload.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Push: in_cmd_valid & in_cmd_ready. Writes the entry at the write pointer and advances the write pointer.
- in_cmd_ready = (count != DEPTH). A pop in the same cycle does not open a slot combinationally.
- Release gate: out_cmd_valid = (count != 0) & (~exp_rsp(head) | outst_cnt < MAX_OUTST).
  - A gated head blocks all entries behind it. Strict in-order release; no reordering.
- Pop: out_cmd_valid & out_cmd_ready. Advances the read pointer.
  - If the popped head has exp_rsp=1, outst_cnt increments.
- Response path is purely combinational passthrough:
  - in_rsp_* = out_rsp_*.
  - out_rsp_ready = in_rsp_ready.
- Retire: out_rsp_valid & out_rsp_ready & (out_rsp_opc[3:2] != 2'b10).
  - Posted-write error responses are forwarded but do not retire.
  - A retire decrements outst_cnt.
- Simultaneous pop(exp_rsp) and retire: outst_cnt unchanged.
- Retire with outst_cnt==0: outst_cnt stays 0 (no underflow) and outst_err sets.
  - outst_err clears only on reset.
- Simultaneous push and pop: count unchanged; both pointers advance.

## Timing
- Reset values:
  - Pointers and count: 0.
  - out_cmd_valid: 0.
  - in_cmd_ready: 1.
  - outst_cnt: 0.
  - idle: 1.
  - outst_err: 0.
  - in_rsp_valid follows out_rsp_valid.
  - Payload registers are not reset.
- Push-to-release latency: 1 cycle. A command pushed in cycle N is presented on out_cmd_* in cycle N+1 at the earliest. There is no empty bypass.
- out_cmd_* payload is stable while out_cmd_valid=1 and out_cmd_ready=0.
  - out_cmd_valid drops only on a pop or reset.
  - A retire can raise out_cmd_valid in the cycle after it occurs.
- Gate re-evaluation: outst_cnt is a register, so a retire in cycle N unblocks a gated head in cycle N+1.
- Full throughput: one push and one pop per cycle in steady state.
- Reset asserted mid-operation: queued commands are discarded, outst_cnt returns to 0, and all outputs take reset values asynchronously.

## Test plan
- Reset, then push one read (tag 1, addr 0x1000) with out_cmd_ready=1 -> out_cmd_valid rises next cycle with addr 0x1000; outst_cnt=1; idle=0. Return a response with opc 0000 -> outst_cnt=0, idle=1.
- With out_cmd_ready=0, push DEPTH=4 commands -> in_cmd_ready=0 after the 4th. A 5th valid is held off. Pop one -> in_cmd_ready=1 the following cycle. Output order matches push order, checked by tag 0..3.
- MAX_OUTST=2: push reads A, B, C and posted write D, with no responses -> A and B issue; C gated; D blocked behind C. One response -> C issues the next cycle, then D.
- Posted write whose response has opc 1001 (posted-write error) -> forwarded to in_rsp_* unchanged; outst_cnt unchanged.
- Pop a read while retiring a response in the same cycle at outst_cnt=1 -> outst_cnt stays 1.
- Spurious response at outst_cnt=0 -> outst_err=1 and outst_cnt stays 0. Assert rst_l low mid-queue with 3 entries -> out_cmd_valid=0 and idle=1 immediately.
